// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: oversampled start/data/parity/stop decode
// with per-frame error flags and a valid/ready output holding one frame.
module uart_rx_cfg #(
  parameter int OVERSAMBLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int MSB_FIRST  = 1,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int SC_W = $clog2(OVERSAMBLE);
  localparam int BC_W = $clog2(DATA_BITS + 1);
  localparam logic [SC_W-1:0] SC_HALF = SC_W'(OVERSAMBLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_FULL = SC_W'(OVERSAMBLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_e;

  function automatic logic exp_parity(input logic [DATA_BITS-1:0] d, input logic [1:0] m);
    case (m)
      2'b01:   return ^d;
      2'b10:   return ~^d;
      default: return 1'b1;
    endcase
  endfunction

  state_e                 state_q;
  logic                   meta_q, rxs_q;
  logic [DIV_WIDTH-1:0]   div_cnt_q, div_cfg_q, div_lim_d;
  logic [1:0]             pmode_q;
  logic                   two_stop_q;
  logic [SC_W-1:0]        sc_q;
  logic [BC_W-1:0]        bc_q;
  logic                   stc_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   pbit_q, perr_q, ferr_q, brk_q, deliver_q;
  logic                   tick_d, accept_d, ferr_d;

  // Terminal count of the tick divider; a divisor of 0 behaves like 1.
  always_comb begin
    div_lim_d = '0;
    if (div_cfg_q != '0) begin
      div_lim_d = div_cfg_q - DIV_WIDTH'(1);
    end else begin
      div_lim_d = '0;
    end
    tick_d   = (div_cnt_q >= div_lim_d);
    accept_d = rx_valid && rx_ready;
    ferr_d   = ferr_q | ~rxs_q;
  end

  // Two-flop synchronizer, preset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= rx;
      rxs_q  <= meta_q;
    end
  end

  // Free-running oversample tick generator.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else if (tick_d) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
    end
  end

  // Receive FSM; configuration is captured only while idle so a frame sees a stable setup.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_cfg_q  <= '0;
      pmode_q    <= 2'b00;
      two_stop_q <= 1'b0;
      sc_q       <= '0;
      bc_q       <= '0;
      stc_q      <= 1'b0;
      data_q     <= '0;
      pbit_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      deliver_q  <= 1'b0;
    end else begin
      deliver_q <= 1'b0;
      if (state_q == IDLE) begin
        div_cfg_q  <= baud_div;
        pmode_q    <= parity_mode;
        two_stop_q <= two_stop;
      end
      if (tick_d) begin
        case (state_q)
          IDLE: begin
            if (!rxs_q) begin
              state_q <= START;
              sc_q    <= '0;
            end
          end
          START: begin
            if (sc_q == SC_HALF) begin
              if (!rxs_q) begin
                state_q <= DATA;
                sc_q    <= '0;
                bc_q    <= '0;
                stc_q   <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
                brk_q   <= 1'b0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              sc_q <= sc_q + SC_W'(1);
            end
          end
          DATA: begin
            if (sc_q == SC_FULL) begin
              sc_q <= '0;
              bc_q <= bc_q + BC_W'(1);
              if (MSB_FIRST != 0) begin
                data_q <= {data_q[DATA_BITS-2:0], rxs_q};
              end else begin
                data_q <= {rxs_q, data_q[DATA_BITS-1:1]};
              end
              if (bc_q == BC_LAST) begin
                state_q <= (pmode_q != 2'b00) ? PARITY : STOP;
              end
            end else begin
              sc_q <= sc_q + SC_W'(1);
            end
          end
          PARITY: begin
            if (sc_q == SC_FULL) begin
              sc_q    <= '0;
              pbit_q  <= rxs_q;
              perr_q  <= (rxs_q != exp_parity(data_q, pmode_q));
              state_q <= STOP;
            end else begin
              sc_q <= sc_q + SC_W'(1);
            end
          end
          STOP: begin
            if (sc_q == SC_FULL) begin
              sc_q   <= '0;
              ferr_q <= ferr_d;
              if (!stc_q) begin
                brk_q <= (data_q == '0) && ((pmode_q == 2'b00) || !pbit_q) && !rxs_q;
              end
              if (stc_q || !two_stop_q) begin
                deliver_q <= 1'b1;
                state_q   <= ferr_d ? WAIT_HIGH : IDLE;
              end else begin
                stc_q <= 1'b1;
              end
            end else begin
              sc_q <= sc_q + SC_W'(1);
            end
          end
          WAIT_HIGH: begin
            if (rxs_q) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Output holding register: a delivery into an occupied, unaccepted slot is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else if (deliver_q) begin
      if (!rx_valid || accept_d) begin
        rx_data    <= data_q;
        rx_valid   <= 1'b1;
        parity_err <= perr_q;
        frame_err  <= ferr_q;
        break_det  <= brk_q;
        overrun    <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (accept_d) begin
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_valid <= rx_valid;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed scenarios plus randomized frames
// compared against a rule-level reference model.
module tb_uart_rx_cfg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = 16'd1;
  logic [1:0]  parity_mode = 2'b00;
  logic        two_stop = 1'b0;
  logic        rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        parity_err, frame_err, break_det, overrun;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
    logic       ov;
  } frm_t;

  frm_t acc_q[$];

  uart_rx_cfg dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_mode(parity_mode),
    .two_stop(two_stop), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
    .break_det(break_det), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Record every accepted frame (the handshake completes on the following rising edge).
  always @(negedge clk) begin
    #1;
    if (!rst && rx_valid && rx_ready) begin
      acc_q.push_back('{rx_data, parity_err, frame_err, break_det, overrun});
    end
  end

  // Reference model: flags derived directly from the framing rules.
  function automatic frm_t model(input logic [7:0] d, input logic pbit, input logic [1:0] pm,
                                 input logic s1, input logic s2, input logic ts);
    frm_t r;
    logic exp_p;
    exp_p = (pm == 2'b01) ? logic'($countones(d) % 2) :
            (pm == 2'b10) ? logic'(($countones(d) + 1) % 2) : 1'b1;
    r.d  = d;
    r.pe = (pm != 2'b00) && (pbit != exp_p);
    r.fe = !s1 || (ts && !s2);
    r.bk = (d == 8'd0) && ((pm == 2'b00) || !pbit) && !s1;
    r.ov = 1'b0;
    return r;
  endfunction

  function automatic int bit_clks();
    return 16 * ((baud_div == 16'd0) ? 1 : int'(baud_div));
  endfunction

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s1, input logic s2);
    int bc;
    bc = bit_clks();
    drive_bit(1'b0, bc);
    for (int i = 7; i >= 0; i--) drive_bit(d[i], bc);
    if (parity_mode != 2'b00) drive_bit(pbit, bc);
    drive_bit(s1, bc);
    if (two_stop) drive_bit(s2, bc);
    drive_bit(1'b1, 2 * bc);
  endtask

  task automatic set_cfg(input logic [15:0] div, input logic [1:0] pm, input logic ts);
    baud_div = div;
    parity_mode = pm;
    two_stop = ts;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!rx_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic accept_one();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
    checks++; if (rx_data !== 8'h00)   begin errors++; $display("FAIL reset_data got %h exp 00", rx_data); end
    checks++; if ({parity_err, frame_err, break_det, overrun} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags got %b exp 0000", {parity_err, frame_err, break_det, overrun}); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    set_cfg(16'd1, 2'b01, 1'b0);
    acc_q.delete();
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    rx_ready = 1'b0;
    checks++; if (acc_q.size() !== 1) begin errors++; $display("FAIL basic_count got %0d exp 1", acc_q.size()); end
    if (acc_q.size() > 0) begin
      checks++; if (acc_q[0] !== model(8'hA5, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0))
        begin errors++; $display("FAIL basic_frame got %h exp %h", acc_q[0], model(8'hA5, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0)); end
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_low got %b exp 0", rx_valid); end
  endtask

  task automatic test_parity_odd();
    set_cfg(16'd1, 2'b10, 1'b0);
    for (int p = 0; p < 2; p++) begin
      send_frame(8'h3C, logic'(p), 1'b1, 1'b1);
      wait_valid();
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL odd_valid got %b exp 1", rx_valid); end
      checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL odd_data got %h exp 3c", rx_data); end
      checks++; if (parity_err !== (p == 0)) begin errors++; $display("FAIL odd_perr pbit %0d got %b exp %b", p, parity_err, p == 0); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL odd_ferr got %b exp 0", frame_err); end
      accept_one();
    end
  endtask

  task automatic test_two_stop();
    set_cfg(16'd1, 2'b01, 1'b1);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    wait_valid();
    checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL ts_data got %h exp 81", rx_data); end
    checks++; if ({frame_err, break_det} !== 2'b10) begin errors++; $display("FAIL ts_flags got %b exp 10", {frame_err, break_det}); end
    accept_one();
    send_frame(8'h55, 1'b0, 1'b1, 1'b1);
    wait_valid();
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL ts_next_data got %h exp 55", rx_data); end
    checks++; if ({parity_err, frame_err, break_det} !== 3'b000)
      begin errors++; $display("FAIL ts_next_flags got %b exp 000", {parity_err, frame_err, break_det}); end
    accept_one();
  endtask

  task automatic test_back_to_back();
    set_cfg(16'd1, 2'b01, 1'b0);
    acc_q.delete();
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1);
    send_frame(8'h33, 1'b0, 1'b1, 1'b1);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", rx_valid); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data got %h exp 11", rx_data); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun); end
    accept_one();
    checks++; if ({rx_valid, overrun} !== 2'b00) begin errors++; $display("FAIL ovr_clear got %b exp 00", {rx_valid, overrun}); end
    checks++; if (acc_q.size() !== 1) begin errors++; $display("FAIL ovr_count got %0d exp 1", acc_q.size()); end
  endtask

  task automatic test_break();
    set_cfg(16'd1, 2'b01, 1'b0);
    acc_q.delete();
    rx_ready = 1'b1;
    drive_bit(1'b0, 20 * bit_clks());
    checks++; if (acc_q.size() !== 1) begin errors++; $display("FAIL brk_count_low got %0d exp 1", acc_q.size()); end
    drive_bit(1'b1, 3 * bit_clks());
    rx_ready = 1'b0;
    checks++; if (acc_q.size() !== 1) begin errors++; $display("FAIL brk_count got %0d exp 1", acc_q.size()); end
    if (acc_q.size() > 0) begin
      checks++; if (acc_q[0] !== model(8'h00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0))
        begin errors++; $display("FAIL brk_frame got %h exp %h", acc_q[0], model(8'h00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0)); end
    end
  endtask

  task automatic test_glitch_reset();
    int bc;
    set_cfg(16'd1, 2'b01, 1'b0);
    acc_q.delete();
    rx_ready = 1'b1;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 60);
    checks++; if (acc_q.size() !== 0) begin errors++; $display("FAIL glitch_count got %0d exp 0", acc_q.size()); end
    bc = bit_clks();
    drive_bit(1'b0, bc);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, bc);
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 * bc) @(negedge clk);
    checks++; if (acc_q.size() !== 0) begin errors++; $display("FAIL rst_count got %0d exp 0", acc_q.size()); end
    checks++; if ({rx_valid, rx_data, parity_err, frame_err, break_det, overrun} !== 13'd0)
      begin errors++; $display("FAIL rst_outputs got %h exp 0", {rx_valid, rx_data, parity_err, frame_err, break_det, overrun}); end
    send_frame(8'hF0, 1'b0, 1'b1, 1'b1);
    rx_ready = 1'b0;
    checks++; if (acc_q.size() !== 1) begin errors++; $display("FAIL rst_next_count got %0d exp 1", acc_q.size()); end
    if (acc_q.size() > 0) begin
      checks++; if (acc_q[0] !== model(8'hF0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0))
        begin errors++; $display("FAIL rst_next_frame got %h exp %h", acc_q[0], model(8'hF0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0)); end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       pbit, s1, s2, ts;
    logic [1:0] pm;
    frm_t       exp_f;
    for (int k = 0; k < 24; k++) begin
      pm = 2'($urandom_range(0, 3));
      ts = 1'($urandom_range(0, 1));
      set_cfg(16'($urandom_range(0, 3)), pm, ts);
      d    = 8'($urandom);
      pbit = 1'($urandom_range(0, 1));
      s1   = ($urandom_range(0, 7) != 0);
      s2   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) begin
        d = 8'h00;
        pbit = 1'b0;
        s1 = 1'b0;
      end
      exp_f = model(d, pbit, pm, s1, s2, ts);
      send_frame(d, pbit, s1, s2);
      wait_valid();
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rnd_valid #%0d got %b exp 1", k, rx_valid); end
      checks++; if ({rx_data, parity_err, frame_err, break_det, overrun} !== exp_f)
        begin errors++; $display("FAIL rnd_frame #%0d got %h exp %h", k, {rx_data, parity_err, frame_err, break_det, overrun}, exp_f); end
      accept_one();
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rnd_accept #%0d got %b exp 0", k, rx_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_odd();
    test_two_stop();
    test_back_to_back();
    test_break();
    test_glitch_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
